// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sequencer and its bench.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_OFFER  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_GATE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_ENTER = 2'd0,
    MODE_EXIT  = 2'd1,
    MODE_IDLE  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_ALT    = 2'd1,
    ACT_CHOSEN = 2'd2,
    ACT_EXIT   = 2'd3
  } action_e;

  typedef enum logic [2:0] {
    RES_NONE     = 3'd0,
    RES_INVALID  = 3'd1,
    RES_SPECIAL  = 3'd2,
    RES_CHOSEN   = 3'd3,
    RES_ALT      = 3'd4,
    RES_DECLINED = 3'd5,
    RES_FULL     = 3'd6,
    RES_EXITED   = 3'd7
  } result_e;

  typedef enum logic {
    LANE_ENT  = 1'b0,
    LANE_EXIT = 1'b1
  } lane_e;

  localparam int unsigned ID_W = 28;
  localparam logic [19:0] ID_PREFIX = 20'h20230;

  // Site IDs share a fixed 20-bit prefix; only the low byte varies per card.
  function automatic logic id_has_prefix(input logic [ID_W-1:0] id);
    return (id[ID_W-1:8] == ID_PREFIX);
  endfunction

endpackage

// File: rtl/parking_gate_sequencer_if.sv
// Lane, driver and bookkeeping signals of the gate sequencer, grouped per side.
interface parking_gate_sequencer_if;

  logic        ent_req;
  logic [27:0] ent_id;
  logic        ent_flr;
  logic        exit_req;
  logic [27:0] exit_id;
  logic        alt_accept;
  logic        alt_reject;
  logic        fl_id_valid;
  logic        fl_id_special;
  logic        fl_chosen_full;
  logic        fl_alt_full;
  logic [27:0] fl_id;
  logic [1:0]  fl_mode;
  logic        fl_chosen_flr;
  logic [1:0]  fl_action;
  logic        ent_ack;
  logic        exit_ack;
  logic        ent_gate_open;
  logic        exit_gate_open;
  logic        offer_alt;
  logic        result_valid;
  logic [2:0]  result_code;
  logic        busy;

  modport slave (
    input  ent_req, ent_id, ent_flr, exit_req, exit_id, alt_accept, alt_reject,
           fl_id_valid, fl_id_special, fl_chosen_full, fl_alt_full,
    output fl_id, fl_mode, fl_chosen_flr, fl_action, ent_ack, exit_ack,
           ent_gate_open, exit_gate_open, offer_alt, result_valid, result_code, busy
  );

  modport master (
    output ent_req, ent_id, ent_flr, exit_req, exit_id, alt_accept, alt_reject,
           fl_id_valid, fl_id_special, fl_chosen_full, fl_alt_full,
    input  fl_id, fl_mode, fl_chosen_flr, fl_action, ent_ack, exit_ack,
           ent_gate_open, exit_gate_open, offer_alt, result_valid, result_code, busy
  );

endinterface

// File: rtl/parking_lane_arb.sv
// Two-lane round-robin arbiter; a grant is only issued while the sequencer is idle.
module parking_lane_arb
  import parking_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_ent_i,
  input  logic req_exit_i,
  input  logic accept_i,
  output logic grant_ent_o,
  output logic grant_exit_o
);

  lane_e last_q;
  lane_e last_d;

  // Grant selection; on contention the lane not served last wins.
  always_comb begin
    grant_ent_o  = 1'b0;
    grant_exit_o = 1'b0;
    if (accept_i && req_ent_i && req_exit_i) begin
      if (last_q == LANE_EXIT) begin
        grant_ent_o = 1'b1;
      end else begin
        grant_exit_o = 1'b1;
      end
    end else if (accept_i && req_ent_i) begin
      grant_ent_o = 1'b1;
    end else if (accept_i && req_exit_i) begin
      grant_exit_o = 1'b1;
    end else begin
      grant_ent_o  = 1'b0;
      grant_exit_o = 1'b0;
    end

    if (grant_ent_o) begin
      last_d = LANE_ENT;
    end else if (grant_exit_o) begin
      last_d = LANE_EXIT;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; reset as exit so entry wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= LANE_EXIT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/parking_gate_sequencer.sv
// Sequences entry/exit lanes onto the shared bookkeeping block: lookup, optional
// alternative-floor offer, single commit pulse, then a timed gate-open window.
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int GATE_OPEN_CYCLES = 8,
  parameter int OFFER_TIMEOUT    = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  parking_gate_sequencer_if.slave  bus
);

  localparam int OFR_W  = $clog2(OFFER_TIMEOUT + 1);
  localparam int GATE_W = $clog2(GATE_OPEN_CYCLES + 1);
  localparam logic [OFR_W-1:0]  OFR_LAST  = OFR_W'(OFFER_TIMEOUT - 1);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_OPEN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [OFR_W-1:0]   ofr_cnt_q, ofr_cnt_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  lane_e              lane_q, lane_d;
  logic [ID_W-1:0]    fl_id_q, fl_id_d;
  logic [1:0]         fl_mode_q, fl_mode_d;
  logic               fl_flr_q, fl_flr_d;
  logic [1:0]         fl_action_q, fl_action_d;
  logic [2:0]         result_code_q, result_code_d;
  logic               ent_ack_q, ent_ack_d;
  logic               exit_ack_q, exit_ack_d;
  logic               ent_gate_q, exit_gate_q, offer_q, result_valid_q, busy_q;
  logic               grant_ent_s, grant_exit_s;

  parking_lane_arb u_arb (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .req_ent_i    (bus.ent_req),
    .req_exit_i   (bus.exit_req),
    .accept_i     (state_q == ST_IDLE),
    .grant_ent_o  (grant_ent_s),
    .grant_exit_o (grant_exit_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    ofr_cnt_d     = ofr_cnt_q;
    gate_cnt_d    = gate_cnt_q;
    lane_d        = lane_q;
    fl_id_d       = fl_id_q;
    fl_mode_d     = fl_mode_q;
    fl_flr_d      = fl_flr_q;
    fl_action_d   = ACT_NONE;
    result_code_d = RES_NONE;
    ent_ack_d     = 1'b0;
    exit_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_ent_s) begin
          ent_ack_d = 1'b1;
          lane_d    = LANE_ENT;
          fl_id_d   = bus.ent_id;
          fl_mode_d = MODE_ENTER;
          fl_flr_d  = bus.ent_flr;
          state_d   = ST_LOOKUP;
        end else if (grant_exit_s) begin
          exit_ack_d = 1'b1;
          lane_d     = LANE_EXIT;
          fl_id_d    = bus.exit_id;
          fl_mode_d  = MODE_EXIT;
          fl_flr_d   = 1'b0;
          state_d    = ST_LOOKUP;
        end else begin
          fl_mode_d = MODE_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (bus.fl_id_special) begin
          state_d       = ST_COMMIT;
          result_code_d = RES_SPECIAL;
        end else if (lane_q == LANE_EXIT) begin
          if (bus.fl_id_valid) begin
            state_d       = ST_COMMIT;
            fl_action_d   = ACT_EXIT;
            result_code_d = RES_EXITED;
          end else begin
            state_d       = ST_DONE;
            result_code_d = RES_INVALID;
          end
        end else if (!bus.fl_id_valid) begin
          state_d       = ST_DONE;
          result_code_d = RES_INVALID;
        end else if (!bus.fl_chosen_full) begin
          state_d       = ST_COMMIT;
          fl_action_d   = ACT_CHOSEN;
          result_code_d = RES_CHOSEN;
        end else if (!bus.fl_alt_full) begin
          state_d   = ST_OFFER;
          ofr_cnt_d = '0;
        end else begin
          state_d       = ST_DONE;
          result_code_d = RES_FULL;
        end
      end
      ST_OFFER: begin
        // Reject is checked first so a simultaneous answer is treated as a decline.
        if (bus.alt_reject) begin
          state_d       = ST_DONE;
          result_code_d = RES_DECLINED;
        end else if (bus.alt_accept) begin
          state_d       = ST_COMMIT;
          fl_action_d   = ACT_ALT;
          result_code_d = RES_ALT;
        end else if (ofr_cnt_q == OFR_LAST) begin
          state_d       = ST_DONE;
          result_code_d = RES_DECLINED;
        end else begin
          ofr_cnt_d = ofr_cnt_q + OFR_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d    = ST_GATE;
        gate_cnt_d = GATE_LOAD;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        fl_mode_d = MODE_IDLE;
      end
      ST_GATE: begin
        if (gate_cnt_q == '0) begin
          state_d   = ST_IDLE;
          fl_mode_d = MODE_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        fl_mode_d = MODE_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset closes gates and drops any offer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      ofr_cnt_q      <= '0;
      gate_cnt_q     <= '0;
      lane_q         <= LANE_ENT;
      fl_id_q        <= '0;
      fl_mode_q      <= MODE_IDLE;
      fl_flr_q       <= 1'b0;
      fl_action_q    <= ACT_NONE;
      result_code_q  <= RES_NONE;
      ent_ack_q      <= 1'b0;
      exit_ack_q     <= 1'b0;
      ent_gate_q     <= 1'b0;
      exit_gate_q    <= 1'b0;
      offer_q        <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ofr_cnt_q      <= ofr_cnt_d;
      gate_cnt_q     <= gate_cnt_d;
      lane_q         <= lane_d;
      fl_id_q        <= fl_id_d;
      fl_mode_q      <= fl_mode_d;
      fl_flr_q       <= fl_flr_d;
      fl_action_q    <= fl_action_d;
      result_code_q  <= result_code_d;
      ent_ack_q      <= ent_ack_d;
      exit_ack_q     <= exit_ack_d;
      ent_gate_q     <= (state_d == ST_GATE) && (lane_d == LANE_ENT);
      exit_gate_q    <= (state_d == ST_GATE) && (lane_d == LANE_EXIT);
      offer_q        <= (state_d == ST_OFFER);
      result_valid_q <= (state_d == ST_COMMIT) || (state_d == ST_DONE);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign bus.fl_id          = fl_id_q;
  assign bus.fl_mode        = fl_mode_q;
  assign bus.fl_chosen_flr  = fl_flr_q;
  assign bus.fl_action      = fl_action_q;
  assign bus.ent_ack        = ent_ack_q;
  assign bus.exit_ack       = exit_ack_q;
  assign bus.ent_gate_open  = ent_gate_q;
  assign bus.exit_gate_open = exit_gate_q;
  assign bus.offer_alt      = offer_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_code    = result_code_q;
  assign bus.busy           = busy_q;

endmodule

// File: doc/parking_gate_sequencer.md
# parking_gate_sequencer

Sequences the parking controller's entry and exit lanes onto the single shared floor/ID bookkeeping block. Arbitrates lane requests round-robin, presents ID/MODE/floor to the bookkeeping block, and decides the outcome from its status flags. Runs the alternative-floor offer handshake, issues exactly one `action_taken` commit pulse per admitted car, and times the gate-open window.

## Interface
- `GATE_OPEN_CYCLES`, 8: cycles a gate stays open; must be ≥1.
- `OFFER_TIMEOUT`, 16: cycles to wait for a driver's answer to an alternative-floor offer; must be ≥1.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `ent_req` in 1: entry lane request; level, held until `ent_ack`.
- `ent_id` in 28: entry ID; stable while `ent_req` is high.
- `ent_flr` in 1: requested floor (0/1).
- `exit_req` in 1: exit lane request; level, held until `exit_ack`.
- `exit_id` in 28: exit ID.
- `alt_accept`, `alt_reject` in 1: driver answer while `offer_alt` is high.
- `fl_id_valid`, `fl_id_special`, `fl_chosen_full`, `fl_alt_full` in 1: bookkeeping status, combinational on `fl_id`/`fl_mode`/`fl_chosen_flr`.
- `fl_id` out 28, `fl_mode` out 2, `fl_chosen_flr` out 1, `fl_action` out 2: drive the bookkeeping block.
- `ent_ack`, `exit_ack` out 1: one-cycle grant pulses.
- `ent_gate_open`, `exit_gate_open` out 1: gate drive.
- `offer_alt` out 1: alternative floor offered.
- `result_valid` out 1: one-cycle pulse; `result_code` out 3: outcome.
- `busy` out 1: high in every state except IDLE.

## Operation
- Encodings: MODE 0 = enter, 1 = exit, 2 = idle/restrict. Action 0 = none, 1 = alternative floor, 2 = chosen floor, 3 = exit.
- Result codes: 1 INVALID, 2 SPECIAL, 3 CHOSEN, 4 ALT, 5 DECLINED, 6 FULL, 7 EXITED.
- States: IDLE, LOOKUP, OFFER, COMMIT, DONE, GATE.
- IDLE: `fl_mode`=2, `fl_action`=0.
  - One request: grant it.
  - Both requests: grant the lane not granted last. After reset, entry wins first.
  - On grant: pulse ack, register id/floor/mode into `fl_*`, go to LOOKUP.
- LOOKUP lasts one cycle. Decision is sampled at its closing edge.
  - Entry:
    - special → COMMIT, action 0, code 2.
    - not valid → DONE, code 1.
    - valid and chosen floor not full → COMMIT, action 2, code 3.
    - chosen floor full, alternative not full → OFFER.
    - both full → DONE, code 6.
  - Exit:
    - special → COMMIT, action 0, code 2.
    - valid → COMMIT, action 3, code 7.
    - otherwise → DONE, code 1.
- OFFER: `offer_alt` high.
  - `alt_reject` → DONE, code 5. Reject wins if both answers are asserted together.
  - `alt_accept` → COMMIT, action 1, code 4.
  - `OFFER_TIMEOUT` cycles with no answer → DONE, code 5.
- COMMIT lasts one cycle.
  - `fl_action` is nonzero only in this cycle.
  - `result_valid` is high this cycle.
  - Next state is GATE.
- DONE lasts one cycle: `result_valid` high, then IDLE.
- GATE: the granted lane's gate is open for exactly `GATE_OPEN_CYCLES` cycles, then IDLE.
- Requests arriving while busy are not acknowledged. Requesters keep `req` held.
- Reset values: all outputs 0 except `fl_mode`=2; state IDLE; counters 0; last-grant = exit.
- Reset mid-operation: gates close immediately, nothing is committed, and a pending offer is dropped.

## Timing
- Edge E0 samples `req` in IDLE → ack high during E0–E1; `fl_*` valid from E0.
- E1 decides. In COMMIT/DONE, `result_valid` is high during E1–E2. The bookkeeping block updates at E2.
- Gate high from E2 through E2+N, with N = `GATE_OPEN_CYCLES`.
- Fastest admit: request-to-gate-open is 2 cycles; back in IDLE at E2+N.
- OFFER counter: width clog2(`OFFER_TIMEOUT`+1). It starts at 0 on entering OFFER; timeout fires on the edge where it reaches `OFFER_TIMEOUT`−1 with no answer.
- Gate counter: loaded with N−1 on entering GATE, counts down, exits at 0. There is no wrap.

## Structure
- Shared package `parking_pkg`:
  - state enum
  - MODE and action encodings
  - result codes
  - the 20-bit ID prefix constant
- Sub-module `parking_lane_arb`: two-requester round-robin arbiter with last-grant register; grant is accepted only in IDLE.

## Test plan
- Entry, ID 0x2023010, floor 1, not full → `ent_ack` at +1; `fl_action`=2 for one cycle; code 3; gate open 8 cycles.
- Entry with chosen floor full, alternative free; `alt_accept` 3 cycles into OFFER → `fl_action`=1 once; code 4. Repeat with no answer → code 5 after 16 cycles; no commit.
- Both floors full → DONE, code 6; gates stay closed; `fl_action` stays 0.
- `ent_req` and `exit_req` asserted together, twice in a row → entry granted first, then exit; exit ID 0x2023010 → `fl_action`=3, code 7.
- Special ID 0x2023000 on entry → code 2; `fl_action` stays 0; gate opens. Unknown ID 0x2023099 → code 1.
- `RST_N` low during GATE, and again during COMMIT → gate drops immediately, `fl_mode`=2, no action pulse; the next request is serviced normally.
